// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the unified memory port: requester owner tag,
// word offset and byte-alignment mask.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

  localparam int unsigned WORD_OFFSET = 2;
  localparam logic [1:0]  ALIGN_MASK  = 2'b11;

  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb & ALIGN_MASK) == '0;
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Starvation guard for instruction fetch: counts consecutive cycles IF loses to LS
// and raises force_if once the count saturates at MAX_WAIT.
module mem_arb_starve_ctr #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic if_req_valid,
  input  logic if_flush,
  input  logic if_grant,
  input  logic ls_grant,
  output logic force_if
);

  localparam int unsigned CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  logic [CW-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (!if_req_valid || if_grant) begin
      count_d = '0;
    end else if (ls_grant && !if_flush && (count_q != MAX_CNT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign force_if = (count_q == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and LS onto one synchronous-read memory port with 1-cycle responses.
// Optional IF starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MEM_AW   = 8,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  output logic              if_rsp_err,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rsp_data,
  output logic              ls_rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              force_if;
  logic              if_grant, ls_grant;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] rd_data;
  owner_e            owner_d, owner_q;
  logic              err_d, err_q;
  logic              we_d, we_q;

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve_ctr (
    .clk          (clk),
    .reset_n      (reset_n),
    .if_req_valid (if_req_valid),
    .if_flush     (if_flush),
    .if_grant     (if_grant),
    .ls_grant     (ls_grant),
    .force_if     (force_if)
  );
`else
  assign force_if = 1'b0;
  logic [31:0] unused_max_wait;
  assign unused_max_wait = 32'(MAX_WAIT);
`endif

  // Memory is addressed modulo its size; upper byte-address bits are dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{if_addr[ADDR_W-1:MEM_AW+2], ls_addr[ADDR_W-1:MEM_AW+2]};

  // Ready is gated by reset_n directly so it drops asynchronously with reset.
  always_comb begin
    if_req_ready = 1'b0;
    ls_req_ready = 1'b0;
    if (reset_n) begin
      if_req_ready = !if_flush && (!ls_req_valid || force_if);
      ls_req_ready = !(force_if && if_req_valid && !if_flush);
    end
    if_grant = if_req_valid && if_req_ready;
    ls_grant = ls_req_valid && ls_req_ready;
  end

  always_comb begin
    sel_addr  = '0;
    owner_d   = OWN_NONE;
    we_d      = 1'b0;
    err_d     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (ls_grant) begin
      sel_addr = ls_addr;
      owner_d  = OWN_LS;
      we_d     = ls_we;
    end else if (if_grant) begin
      sel_addr = if_addr;
      owner_d  = OWN_IF;
    end
    if (owner_d != OWN_NONE) begin
      err_d  = !is_aligned(sel_addr[1:0]);
      mem_en = !err_d;
      mem_we = !err_d && we_d;
      if (mem_we) mem_wdata = ls_wdata;
    end
    mem_addr = sel_addr[MEM_AW+1:WORD_OFFSET];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q <= OWN_NONE;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      owner_q <= owner_d;
      err_q   <= err_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    rd_data      = (err_q || we_q) ? '0 : mem_rdata;
    if_rsp_valid = 1'b0;
    if_rsp_data  = '0;
    if_rsp_err   = 1'b0;
    ls_rsp_valid = 1'b0;
    ls_rsp_data  = '0;
    ls_rsp_err   = 1'b0;
    if (owner_q == OWN_IF && !if_flush) begin
      if_rsp_valid = 1'b1;
      if_rsp_data  = rd_data;
      if_rsp_err   = err_q;
    end
    if (owner_q == OWN_LS) begin
      ls_rsp_valid = 1'b1;
      ls_rsp_data  = rd_data;
      ls_rsp_err   = err_q;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural synchronous-read memory.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MEM_AW = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              if_req_valid, if_req_ready, if_flush;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rsp_valid, if_rsp_err;
  logic [DATA_W-1:0] if_rsp_data;
  logic              ls_req_valid, ls_req_ready, ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_rsp_valid, ls_rsp_err;
  logic [DATA_W-1:0] ls_rsp_data;
  logic              mem_en, mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  mem_port_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MEM_AW   (MEM_AW),
    .MAX_WAIT (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_addr      (if_addr),
    .if_flush     (if_flush),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_data  (if_rsp_data),
    .if_rsp_err   (if_rsp_err),
    .ls_req_valid (ls_req_valid),
    .ls_req_ready (ls_req_ready),
    .ls_we        (ls_we),
    .ls_addr      (ls_addr),
    .ls_wdata     (ls_wdata),
    .ls_rsp_valid (ls_rsp_valid),
    .ls_rsp_data  (ls_rsp_data),
    .ls_rsp_err   (ls_rsp_err),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory array; a few words are preloaded while reset is held.
  logic [DATA_W-1:0] mem [256];
  always @(posedge clk) begin
    if (!reset_n) begin
      mem[1] <= 32'h1111_0001;
      mem[2] <= 32'hDEAD_BEEF;
      mem[3] <= 32'h3333_0003;
      mem[8] <= 32'hA5A5_0008;
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    int unsigned due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t if_q[$];
  exp_t ls_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push_if(input logic [31:0] d, input logic e);
    exp_t x;
    x.due = cyc + 1; x.data = d; x.err = e;
    if_q.push_back(x);
  endtask

  task automatic push_ls(input logic [31:0] d, input logic e);
    exp_t x;
    x.due = cyc + 1; x.data = d; x.err = e;
    ls_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    if_flush     = 1'b0;
    ls_we        = 1'b0;
  endtask

  // Monitor: responses must appear exactly on their due cycle and nowhere else.
  always @(negedge clk) begin
    exp_t e;
    if (if_q.size() > 0 && if_q[0].due == cyc) begin
      e = if_q.pop_front();
      check("if_rsp_valid", 32'(if_rsp_valid), 32'd1);
      check("if_rsp_data", if_rsp_data, e.data);
      check("if_rsp_err", 32'(if_rsp_err), 32'(e.err));
    end else if (if_rsp_valid) begin
      check("if_rsp_unexpected", 32'(if_rsp_valid), 32'd0);
    end
    if (ls_q.size() > 0 && ls_q[0].due == cyc) begin
      e = ls_q.pop_front();
      check("ls_rsp_valid", 32'(ls_rsp_valid), 32'd1);
      check("ls_rsp_data", ls_rsp_data, e.data);
      check("ls_rsp_err", 32'(ls_rsp_err), 32'(e.err));
    end else if (ls_rsp_valid) begin
      check("ls_rsp_unexpected", 32'(ls_rsp_valid), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic if_win;
    reset_n = 1'b0;
    idle();
    if_addr = 32'h8; ls_addr = 32'h20; ls_wdata = 32'hFFFF_FFFF;
    if_req_valid = 1'b1; ls_req_valid = 1'b1; ls_we = 1'b1;
    @(negedge clk);
    check("reset_ctrl", 32'({if_req_ready, ls_req_ready, mem_en, mem_we,
                             if_rsp_valid, ls_rsp_valid, if_rsp_err, ls_rsp_err}), 32'd0);
    check("reset_mem_addr", 32'(mem_addr), 32'd0);
    check("reset_mem_wdata", mem_wdata, 32'd0);
    check("reset_rsp_data", if_rsp_data | ls_rsp_data, 32'd0);
    @(posedge clk); #1;
    idle();
    reset_n = 1'b1;
    tick();

    // IF only read of word 2
    if_req_valid = 1'b1; if_addr = 32'h8;
    push_if(32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    check("if_only_ready", 32'(if_req_ready), 32'd1);
    check("if_only_mem_addr", 32'(mem_addr), 32'd2);
    check("if_only_mem_en_we", 32'({mem_en, mem_we}), 32'b10);
    tick(); idle(); tick();

    // Contested for 10 cycles
    if_req_valid = 1'b1; if_addr = 32'h4;
    ls_req_valid = 1'b1; ls_we = 1'b0; ls_addr = 32'h20;
    for (int i = 1; i <= 10; i++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
      if_win = (i == 5) || (i == 10);
`else
      if_win = 1'b0;
`endif
      if (if_win) push_if(32'h1111_0001, 1'b0);
      else        push_ls(32'hA5A5_0008, 1'b0);
      @(negedge clk);
      check($sformatf("arb%0d_if_ready", i), 32'(if_req_ready), 32'(if_win));
      check($sformatf("arb%0d_ls_ready", i), 32'(ls_req_ready), 32'(!if_win));
      check($sformatf("arb%0d_mem_addr", i), 32'(mem_addr), if_win ? 32'd1 : 32'd8);
      tick();
    end
    idle(); tick();

    // Store then fetch the same word
    ls_req_valid = 1'b1; ls_we = 1'b1; ls_addr = 32'h10; ls_wdata = 32'h1234_5678;
    push_ls(32'h0, 1'b0);
    @(negedge clk);
    check("store_mem_en_we", 32'({mem_en, mem_we}), 32'b11);
    check("store_mem_addr", 32'(mem_addr), 32'd4);
    check("store_mem_wdata", mem_wdata, 32'h1234_5678);
    tick();
    idle();
    if_req_valid = 1'b1; if_addr = 32'h10;
    push_if(32'h1234_5678, 1'b0);
    tick();
    // Upper address bits wrap
    if_addr = 32'hFFFF_F408;
    push_if(32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    check("wrap_mem_addr", 32'(mem_addr), 32'd2);
    tick(); idle(); tick();

    // Misaligned accesses
    ls_req_valid = 1'b1; ls_we = 1'b0; ls_addr = 32'h6;
    push_ls(32'h0, 1'b1);
    @(negedge clk);
    check("mis_load_mem_en", 32'(mem_en), 32'd0);
    tick();
    ls_we = 1'b1; ls_addr = 32'h13; ls_wdata = 32'hCAFE_F00D;
    push_ls(32'h0, 1'b1);
    @(negedge clk);
    check("mis_store_mem_en_we", 32'({mem_en, mem_we}), 32'b00);
    tick();
    idle();
    if_req_valid = 1'b1; if_addr = 32'h9;
    push_if(32'h0, 1'b1);
    @(negedge clk);
    check("mis_fetch_mem_en", 32'(mem_en), 32'd0);
    tick(); idle(); tick();

    // Flush cancels the due IF response and blocks new fetch
    if_req_valid = 1'b1; if_addr = 32'h8;
    tick();
    if_flush = 1'b1; if_addr = 32'hC;
    @(negedge clk);
    check("flush_if_ready", 32'(if_req_ready), 32'd0);
    check("flush_if_rsp", 32'({if_rsp_valid, if_rsp_err}), 32'd0);
    check("flush_if_rsp_data", if_rsp_data, 32'd0);
    check("flush_mem_en", 32'(mem_en), 32'd0);
    tick(); idle(); tick();

    // LS response unaffected by a flush in its response cycle
    if_req_valid = 1'b1; if_addr = 32'h4;
    ls_req_valid = 1'b1; ls_we = 1'b0; ls_addr = 32'h20;
    push_ls(32'hA5A5_0008, 1'b0);
    tick();
    ls_req_valid = 1'b0; if_flush = 1'b1;
    @(negedge clk);
    check("flush_ls_if_ready", 32'(if_req_ready), 32'd0);
    tick(); idle(); tick();

    // Reset during an in-flight load
    ls_req_valid = 1'b1; ls_we = 1'b0; ls_addr = 32'h20;
    tick();
    reset_n = 1'b0;
    if_req_valid = 1'b1;
    #1;
    check("rst_mid_ctrl", 32'({if_req_ready, ls_req_ready, mem_en, mem_we,
                              if_rsp_valid, ls_rsp_valid, if_rsp_err, ls_rsp_err}), 32'd0);
    check("rst_mid_data", if_rsp_data | ls_rsp_data | mem_wdata, 32'd0);
    check("rst_mid_addr", 32'(mem_addr), 32'd0);
    tick(); tick();
    idle();
    reset_n = 1'b1;
    ls_req_valid = 1'b1; ls_we = 1'b0; ls_addr = 32'h20;
    push_ls(32'hA5A5_0008, 1'b0);
    @(negedge clk);
    check("post_rst_ls_ready", 32'(ls_req_ready), 32'd1);
    check("post_rst_mem_en", 32'(mem_en), 32'd1);
    tick(); idle(); tick(); tick();

    check("if_queue_drained", 32'(if_q.size()), 32'd0);
    check("ls_queue_drained", 32'(ls_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
